c7bexu_wb_arb: RTL and testbench

C7BEXU_WB_ARB -- requirements
Module: c7bexu_wb_arb

---
 rtl/c7bexu_wb_arb_if.sv | 26 ++
 rtl/c7bexu_wb_arb.sv | 116 +++++++++++
 tb/tb_c7bexu_wb_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/c7bexu_wb_arb_if.sv
// Write-back arbiter bus: four requester channels in, two register-file
// write ports and the staged-write busy mask out.
interface c7bexu_wb_arb_if;
   logic [3:0]   req_valid;
   logic [19:0]  req_addr;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic         flush;
   logic         wen1;
   logic [4:0]   waddr1;
   logic [31:0]  wdata1;
   logic         wen2;
   logic [4:0]   waddr2;
   logic [31:0]  wdata2;
   logic [31:0]  busy_mask;

   modport slave (
      input  req_valid, req_addr, req_data, flush,
      output req_ready, wen1, waddr1, wdata1, wen2, waddr2, wdata2, busy_mask
   );

   modport master (
      output req_valid, req_addr, req_data, flush,
      input  req_ready, wen1, waddr1, wdata1, wen2, waddr2, wdata2, busy_mask
   );
endinterface

// File: rtl/c7bexu_wb_arb.sv
// Two-port round-robin write-back arbiter: up to two grants per cycle, the
// second skipping any requester that targets the same nonzero register.
module c7bexu_wb_arb #(
   parameter int NREQ = 4
) (
   input  logic          clk,
   input  logic          rst,
   c7bexu_wb_arb_if.slave bus
);
   logic [4:0]      addr_a [NREQ];
   logic [31:0]     data_a [NREQ];

   logic [1:0]      ptr_q, ptr_d;
   logic            wen1_q, wen1_d;
   logic            wen2_q, wen2_d;
   logic [4:0]      waddr1_q, waddr1_d;
   logic [4:0]      waddr2_q, waddr2_d;
   logic [31:0]     wdata1_q, wdata1_d;
   logic [31:0]     wdata2_q, wdata2_d;
   logic [31:0]     busy_q, busy_d;

   logic            found1, found2;
   logic [1:0]      idx, idx1, idx2;
   logic            grant_en;
   logic [NREQ-1:0] ready;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_a[gi] = bus.req_addr[5*gi +: 5];
         assign data_a[gi] = bus.req_data[32*gi +: 32];
      end
   endgenerate

   // Scan from ptr; slot 2 must not collide with slot 1 on a real register.
   always_comb begin
      found1 = 1'b0;
      found2 = 1'b0;
      idx    = ptr_q;
      idx1   = ptr_q;
      idx2   = ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_q + 2'(k);
         if (bus.req_valid[idx]) begin
            if (!found1) begin
               found1 = 1'b1;
               idx1   = idx;
            end else if (!found2 &&
                         !((addr_a[idx] == addr_a[idx1]) && (addr_a[idx1] != 5'd0))) begin
               found2 = 1'b1;
               idx2   = idx;
            end
         end
      end
   end

   always_comb begin
      grant_en = !rst && !bus.flush;
      ready    = '0;
      ptr_d    = ptr_q;
      wen1_d   = 1'b0;
      waddr1_d = waddr1_q;
      wdata1_d = wdata1_q;
      wen2_d   = 1'b0;
      waddr2_d = waddr2_q;
      wdata2_d = wdata2_q;
      if (grant_en && found1) begin
         ready[idx1] = 1'b1;
         wen1_d      = (addr_a[idx1] != 5'd0);
         waddr1_d    = addr_a[idx1];
         wdata1_d    = data_a[idx1];
         ptr_d       = idx1 + 2'd1;
      end
      if (grant_en && found2) begin
         ready[idx2] = 1'b1;
         wen2_d      = (addr_a[idx2] != 5'd0);
         waddr2_d    = addr_a[idx2];
         wdata2_d    = data_a[idx2];
         ptr_d       = idx2 + 2'd1;
      end
      busy_d = '0;
      if (wen1_d) busy_d[waddr1_d] = 1'b1;
      if (wen2_d) busy_d[waddr2_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= 2'd0;
         wen1_q   <= 1'b0;
         wen2_q   <= 1'b0;
         waddr1_q <= 5'd0;
         waddr2_q <= 5'd0;
         wdata1_q <= 32'd0;
         wdata2_q <= 32'd0;
         busy_q   <= 32'd0;
      end else begin
         ptr_q    <= ptr_d;
         wen1_q   <= wen1_d;
         wen2_q   <= wen2_d;
         waddr1_q <= waddr1_d;
         waddr2_q <= waddr2_d;
         wdata1_q <= wdata1_d;
         wdata2_q <= wdata2_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.wen1      = wen1_q;
   assign bus.waddr1    = waddr1_q;
   assign bus.wdata1    = wdata1_q;
   assign bus.wen2      = wen2_q;
   assign bus.waddr2    = waddr2_q;
   assign bus.wdata2    = wdata2_q;
   assign bus.busy_mask = busy_q;
endmodule

// File: tb/tb_c7bexu_wb_arb.sv
// Scoreboard bench for the write-back arbiter: directed cycles push expected
// grants and next-cycle port values; two monitors pop and compare.
module tb_c7bexu_wb_arb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   c7bexu_wb_arb_if bus();

   c7bexu_wb_arb #(.NREQ(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string       name;
      logic [3:0]  rdy;
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        w2;
      logic [4:0]  a2;
      logic [31:0] d2;
      logic [31:0] busy;
   } exp_t;

   exp_t rdy_q[$];
   exp_t out_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic [4:0]  addr [4];
   logic [31:0] data [4];

   task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, want);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      addr[i] = a;
      data[i] = d;
   endtask

   task automatic step(input string nm, input logic r, input logic f, input logic [3:0] v,
                       input logic [3:0] rdy,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic w2, input logic [4:0] a2, input logic [31:0] d2,
                       input logic [31:0] busy);
      exp_t e;
      @(negedge clk);
      rst           = r;
      bus.flush     = f;
      bus.req_valid = v;
      for (int i = 0; i < 4; i++) begin
         bus.req_addr[5*i +: 5]   = addr[i];
         bus.req_data[32*i +: 32] = data[i];
      end
      e.name = nm; e.rdy = rdy;
      e.w1 = w1; e.a1 = a1; e.d1 = d1;
      e.w2 = w2; e.a2 = a2; e.d2 = d2;
      e.busy = busy;
      rdy_q.push_back(e);
      out_q.push_back(e);
      $display("vec %s: rst=%b flush=%b valid=%b expect ready=%b", nm, r, f, v, rdy);
   endtask

   // Grants are combinational: sample well after the inputs change.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rdy_q.size() > 0) begin
            e = rdy_q.pop_front();
            chk(e.name, "req_ready", 64'(bus.req_ready), 64'(e.rdy));
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (out_q.size() > 0) begin
            e = out_q.pop_front();
            chk(e.name, "wen1", 64'(bus.wen1), 64'(e.w1));
            chk(e.name, "port1", {27'd0, bus.waddr1, bus.wdata1}, {27'd0, e.a1, e.d1});
            chk(e.name, "wen2", 64'(bus.wen2), 64'(e.w2));
            chk(e.name, "port2", {27'd0, bus.waddr2, bus.wdata2}, {27'd0, e.a2, e.d2});
            chk(e.name, "busy_mask", 64'(bus.busy_mask), 64'(e.busy));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.req_valid = 4'b0000;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < 4; i++) set_req(i, 5'd0, 32'd0);

      step("reset", 1, 0, 4'b0000, 4'b0000, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0);

      // Single request from requester 2 with ptr at 0.
      set_req(2, 5'd5, 32'hDEADBEEF);
      step("single", 0, 0, 4'b0100, 4'b0100, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 32'h20);
      step("idle1", 0, 0, 4'b0000, 4'b0000, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 32'h0);
      set_req(3, 5'd4, 32'hA0000003);
      step("ptr_wrap", 0, 0, 4'b1000, 4'b1000, 1, 5'd4, 32'hA0000003, 0, 5'd0, 32'd0, 32'h10);

      // All four valid and held: pairs alternate.
      for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0000000 | 32'(i));
      step("rot0", 0, 0, 4'b1111, 4'b0011, 1, 5'd1, 32'hA0000000, 1, 5'd2, 32'hA0000001, 32'h6);
      step("rot1", 0, 0, 4'b1111, 4'b1100, 1, 5'd3, 32'hA0000002, 1, 5'd4, 32'hA0000003, 32'h18);
      step("rot2", 0, 0, 4'b1111, 4'b0011, 1, 5'd1, 32'hA0000000, 1, 5'd2, 32'hA0000001, 32'h6);
      step("rot3", 0, 0, 4'b1111, 4'b1100, 1, 5'd3, 32'hA0000002, 1, 5'd4, 32'hA0000003, 32'h18);

      // Requesters 0 and 1 both target r7: requester 1 is deferred.
      set_req(0, 5'd7, 32'hC0000000);
      set_req(1, 5'd7, 32'hC0000001);
      set_req(3, 5'd9, 32'hC0000003);
      step("conflict", 0, 0, 4'b1011, 4'b1001, 1, 5'd7, 32'hC0000000, 1, 5'd9, 32'hC0000003, 32'h280);
      step("conflict_def", 0, 0, 4'b0010, 4'b0010, 1, 5'd7, 32'hC0000001, 0, 5'd9, 32'hC0000003, 32'h80);

      // r0 write occupies slot 1 but is discarded.
      set_req(0, 5'd0, 32'hE0000000);
      set_req(1, 5'd3, 32'hE0000001);
      step("addr0", 0, 0, 4'b0011, 4'b0011, 0, 5'd0, 32'hE0000000, 1, 5'd3, 32'hE0000001, 32'h8);

      // Flush two cycles with everything valid; ptr (2) must survive.
      for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0000000 | 32'(i));
      step("flush0", 0, 1, 4'b1111, 4'b0000, 0, 5'd0, 32'hE0000000, 0, 5'd3, 32'hE0000001, 32'h0);
      step("flush1", 0, 1, 4'b1111, 4'b0000, 0, 5'd0, 32'hE0000000, 0, 5'd3, 32'hE0000001, 32'h0);
      step("flush_end", 0, 0, 4'b1111, 4'b1100, 1, 5'd3, 32'hA0000002, 1, 5'd4, 32'hA0000003, 32'h18);

      // Reset with both ports writing and flush also high; ptr is 2 before it.
      step("pre_rst", 0, 0, 4'b1111, 4'b0011, 1, 5'd1, 32'hA0000000, 1, 5'd2, 32'hA0000001, 32'h6);
      step("rst_hold", 1, 1, 4'b1111, 4'b0000, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0);
      step("post_rst", 0, 0, 4'b1111, 4'b0011, 1, 5'd1, 32'hA0000000, 1, 5'd2, 32'hA0000001, 32'h6);
      step("idle2", 0, 0, 4'b0000, 4'b0000, 0, 5'd1, 32'hA0000000, 0, 5'd2, 32'hA0000001, 32'h0);

      repeat (3) @(negedge clk);
      chk("drain", "pending", 64'(rdy_q.size() + out_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
